// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage.
// Holds the writeback source selector codes, the load funct3 codes and the
// FSM state encoding, so the top and the load extender agree on them.
package writeback_stage_pkg;

  // Writeback source select (wbsel). Codes not listed fall back to the ALU.
  localparam logic [2:0] WB_ALU   = 3'b001;
  localparam logic [2:0] WB_MEM   = 3'b011;
  localparam logic [2:0] WB_PC4   = 3'b010;
  localparam logic [2:0] WB_IMM   = 3'b110;
  localparam logic [2:0] WB_PCIMM = 3'b111;

  // Load type (funct3). LD and LWU only have meaning when XLEN is 64.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_WRITE    = 2'b10
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: combinational lane extraction and sign/zero extension of a
// load result.
// Ports:
//   funct3    in  3                load type
//   offset    in  log2(XLEN/8)     low byte-address bits of the load
//   mem_rdata in  XLEN             aligned memory word
//   data      out XLEN             extended register value
module load_extend
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic [XLEN-1:0]            data
);

  localparam int OFFW = $clog2(XLEN/8);

  // Halfword and word lanes ignore the address bits below their own size.
  logic [OFFW-1:0] half_off;
  logic [OFFW-1:0] word_off;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [31:0]     lane_w;

  assign half_off = offset & ~OFFW'(1);
  assign word_off = offset & ~OFFW'(3);

  assign lane_b = mem_rdata[{offset,   3'b000} +: 8];
  assign lane_h = mem_rdata[{half_off, 3'b000} +: 16];
  assign lane_w = mem_rdata[{word_off, 3'b000} +: 32];

  always_comb begin
    data = mem_rdata;
    case (funct3)
      F3_LB:   data = XLEN'($signed(lane_b));
      F3_LH:   data = XLEN'($signed(lane_h));
      F3_LW:   data = XLEN'($signed(lane_w));
      F3_LBU:  data = XLEN'(lane_b);
      F3_LHU:  data = XLEN'(lane_h);
      F3_LD:   data = mem_rdata;
      // On a 32-bit datapath LWU is not a real load type and passes through.
      F3_LWU:  data = (XLEN == 64) ? XLEN'(lane_w) : mem_rdata;
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: selects the value written back to the register file,
// waits for load data when needed, and drives a single register-file write.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         upstream handshake (ready only when idle)
//   wbsel, aluout, pc, imm      writeback source select and operands
//   rd, regwrite                destination register and write enable
//   ld_funct3, ld_addr          load type and byte address (low bits used)
//   mem_rvalid, mem_rdata       load data return
//   flush                       drop the instruction in flight
//   rf_we, rf_waddr, rf_wdata   register-file write port
//   err_timeout                 one-cycle pulse when a load is abandoned
// XLEN must be 32 or 64.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      wbsel,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [RA_W-1:0] rd,
  input  logic            regwrite,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] ld_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            flush,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err_timeout
);

  localparam int OFFW  = $clog2(XLEN/8);
  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  wb_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RA_W-1:0]  waddr_reg;
  logic [XLEN-1:0]  wdata_reg;
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [OFFW-1:0]  off_reg;

  logic             accept;
  logic             load_done;
  logic [XLEN-1:0]  wb_result;
  logic [XLEN-1:0]  load_data;

  // Only the byte-offset bits of the load address matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ld_addr[XLEN-1:OFFW];

  // Non-load result mux; additions wrap naturally at XLEN bits.
  always_comb begin
    wb_result = aluout;
    case (wbsel)
      WB_ALU:   wb_result = aluout;
      WB_PC4:   wb_result = pc + XLEN'(4);
      WB_IMM:   wb_result = imm;
      WB_PCIMM: wb_result = pc + imm;
      default:  wb_result = aluout;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3    (funct3_reg),
    .offset    (off_reg),
    .mem_rdata (mem_rdata),
    .data      (load_data)
  );

  // Next state and outputs. Inside WAIT_MEM the priority is
  // flush > arriving data > timeout, so data arriving on the very cycle the
  // counter hits the limit is still written back.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    in_ready    = 1'b0;
    rf_we       = 1'b0;
    err_timeout = 1'b0;
    accept      = 1'b0;
    load_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = (wbsel == WB_MEM) ? ST_WAIT_MEM : ST_WRITE;
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (mem_rvalid) begin
          load_done  = 1'b1;
          state_next = ST_WRITE;
        end else if (cnt_reg == CNT_W'(MEM_TIMEOUT)) begin
          err_timeout = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        rf_we      = we_reg && !flush;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset wins over everything, including the pulses of the current cycle.
    if (reset) begin
      rf_we       = 1'b0;
      err_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      funct3_reg <= '0;
      off_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        waddr_reg  <= rd;
        we_reg     <= regwrite && (rd != '0);
        funct3_reg <= ld_funct3;
        off_reg    <= ld_addr[OFFW-1:0];
        if (wbsel != WB_MEM) begin
          wdata_reg <= wb_result;
        end
      end
      if (load_done) begin
        wdata_reg <= load_data;
      end
    end
  end

  assign rf_waddr = waddr_reg;
  assign rf_wdata = wdata_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage (XLEN=32, MEM_TIMEOUT=4).
// A transaction-level model predicts in_ready, rf_we, err_timeout and the
// write data every cycle; directed cases pin the model with literal values,
// then a randomized phase runs against the model.
module tb_writeback_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      wbsel = 3'b001;
  logic [XLEN-1:0] aluout = '0, pc = '0, imm = '0;
  logic [RA_W-1:0] rd = '0;
  logic            regwrite = 1'b0;
  logic [2:0]      ld_funct3 = 3'b000;
  logic [XLEN-1:0] ld_addr = '0;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            flush = 1'b0;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            err_timeout;

  writeback_stage #(.XLEN(XLEN), .RA_W(RA_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .wbsel(wbsel), .aluout(aluout), .pc(pc), .imm(imm), .rd(rd),
    .regwrite(regwrite), .ld_funct3(ld_funct3), .ld_addr(ld_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit run      = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mux(input logic [2:0] sel, input logic [31:0] a,
                                          input logic [31:0] p, input logic [31:0] i);
    logic [31:0] r;
    case (sel)
      3'b010:  r = p + 32'd4;
      3'b110:  r = i;
      3'b111:  r = p + i;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    int a;
    a = int'(addr % 4);
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  localparam int P_NONE = 0, P_LOAD = 1, P_RES = 2;
  int          pend = P_NONE;
  int          cyc = 0;
  int          wait_start = 0;
  logic [4:0]  pend_rd = '0;
  bit          pend_we = 1'b0;
  logic [31:0] pend_data = '0;
  logic [2:0]  pend_f3 = '0;
  logic [31:0] pend_addr = '0;
  bit          exp_ready, exp_we, exp_err;

  always @(negedge clk) begin
    if (run) begin
      exp_ready = (pend == P_NONE);
      exp_we    = (pend == P_RES) && pend_we && !flush && !reset;
      exp_err   = (pend == P_LOAD) && !reset && !flush && !mem_rvalid &&
                  (cyc - wait_start == TO);
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("rf_we", 64'(rf_we), 64'(exp_we));
      chk("err_timeout", 64'(err_timeout), 64'(exp_err));
      if (exp_we) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(pend_rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(pend_data));
      end
      // advance to what holds after the coming rising edge
      if (reset) pend = P_NONE;
      else if (pend == P_NONE) begin
        if (in_valid && !flush) begin
          pend_rd = rd;
          pend_we = regwrite && (rd != 0);
          if (wbsel == 3'b011) begin
            pend = P_LOAD; wait_start = cyc + 1; pend_f3 = ld_funct3; pend_addr = ld_addr;
          end else begin
            pend = P_RES; pend_data = ref_mux(wbsel, aluout, pc, imm);
          end
        end
      end else if (pend == P_LOAD) begin
        if (flush) pend = P_NONE;
        else if (mem_rvalid) begin
          pend = P_RES; pend_data = ref_load(pend_f3, pend_addr, mem_rdata);
        end else if (cyc - wait_start == TO) pend = P_NONE;
      end else pend = P_NONE;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] sel, input logic [4:0] dst, input logic [2:0] f3,
                       input logic [31:0] addr);
    in_valid = 1'b1; wbsel = sel; rd = dst; regwrite = 1'b1; ld_funct3 = f3; ld_addr = addr;
    next();
    in_valid = 1'b0;
  endtask

  initial begin
    next(); next();
    reset = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset rf_we", 64'(rf_we), 64'd0);
    chk("reset rf_waddr", 64'(rf_waddr), 64'd0);
    chk("reset rf_wdata", 64'(rf_wdata), 64'd0);
    chk("reset err_timeout", 64'(err_timeout), 64'd0);
    $display("reset: in_ready=%0b rf_we=%0b", in_ready, rf_we);
    next();

    // pc+imm wraps
    pc = 32'hFFFF_FFFC; imm = 32'd8;
    issue(3'b111, 5'd5, 3'b000, 32'h0);
    @(negedge clk);
    chk("pcimm rf_we", 64'(rf_we), 64'd1);
    chk("pcimm rf_waddr", 64'(rf_waddr), 64'd5);
    chk("pcimm rf_wdata", 64'(rf_wdata), 64'h0000_0004);
    $display("pc+imm: rf_waddr=%0d rf_wdata=%h", rf_waddr, rf_wdata);
    next();

    // lb from byte 3 after a three-cycle wait
    issue(3'b011, 5'd7, 3'b000, 32'h0000_1003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("lb wait in_ready", 64'(in_ready), 64'd0); next();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80AB_CDEF;
    next();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("lb rf_we", 64'(rf_we), 64'd1);
    chk("lb rf_waddr", 64'(rf_waddr), 64'd7);
    chk("lb rf_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
    $display("lb: rf_wdata=%h", rf_wdata);
    next();

    // lhu from the upper halfword
    issue(3'b011, 5'd8, 3'b101, 32'h0000_0042);
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
    next();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("lhu rf_wdata", 64'(rf_wdata), 64'h0000_8001);
    $display("lhu: rf_wdata=%h", rf_wdata);
    next();

    // timeout: pulse on the fifth wait cycle, then idle
    issue(3'b011, 5'd9, 3'b010, 32'h0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); chk("to early err", 64'(err_timeout), 64'd0); next();
    end
    @(negedge clk);
    chk("to err pulse", 64'(err_timeout), 64'd1);
    chk("to rf_we", 64'(rf_we), 64'd0);
    next();
    @(negedge clk);
    chk("to in_ready after", 64'(in_ready), 64'd1);
    chk("to err cleared", 64'(err_timeout), 64'd0);
    $display("timeout: in_ready=%0b", in_ready);
    next();

    // flush beats load data
    issue(3'b011, 5'd3, 3'b010, 32'h0);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    next();
    flush = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("flush rf_we", 64'(rf_we), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    $display("flush+rvalid: rf_we=%0b", rf_we);
    next();

    // rd=0 never written
    aluout = 32'd123;
    issue(3'b001, 5'd0, 3'b000, 32'h0);
    @(negedge clk);
    chk("rd0 rf_we", 64'(rf_we), 64'd0);
    $display("rd=0: rf_we=%0b", rf_we);
    next();

    // flush in idle blocks acceptance
    in_valid = 1'b1; flush = 1'b1; wbsel = 3'b001; rd = 5'd4;
    next();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle flush in_ready", 64'(in_ready), 64'd1);
    next();

    // flush during write, reset during a load
    issue(3'b110, 5'd6, 3'b000, 32'h0);
    flush = 1'b1;
    next();
    flush = 1'b0;
    issue(3'b011, 5'd10, 3'b000, 32'h0);
    reset = 1'b1; mem_rvalid = 1'b1;
    next();
    reset = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("reset drop rf_we", 64'(rf_we), 64'd0);
    chk("reset drop in_ready", 64'(in_ready), 64'd1);
    $display("reset during load: in_ready=%0b", in_ready);
    next();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      wbsel      = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom_range(0, 7));
      rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      regwrite   = ($urandom_range(0, 4) != 0);
      ld_funct3  = 3'($urandom_range(0, 7));
      ld_addr    = $urandom;
      aluout     = $urandom;
      pc         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      imm        = $urandom;
      mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
      next();
    end
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
